// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
// Field widths come from EXP_W/MAN_W; the helpers derive everything else.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    ZERO,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
    logic inexact;
  } fp_flags_t;

  localparam int MAX_W = 128;

  function automatic int calc_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int calc_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Sign 0, exponent all ones, fraction MSB set; caller slices to W bits.
  function automatic logic [MAX_W-1:0] qnan_word(
    input int exp_w,
    input int man_w
  );
    logic [MAX_W-1:0] w;
    w = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
    w = w | (MAX_W'(1) << (man_w - 1));
    return w;
  endfunction

  // Subnormals classify as ZERO: the datapath flushes them.
  function automatic fp_class_e classify(
    input logic exp_ones,
    input logic exp_zero,
    input logic frac_zero,
    input logic frac_msb
  );
    fp_class_e c;
    c = NORM;
    if (exp_zero) c = ZERO;
    else if (exp_ones && frac_zero) c = INF;
    else if (exp_ones && frac_msb) c = QNAN;
    else if (exp_ones) c = SNAN;
    return c;
  endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Final-stage normalise, round-to-nearest-even, pack and exceptions.
// Purely combinational; the top registers its outputs.
module fp_round_norm
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = calc_w(EXP_W, MAN_W)
) (
  input  fp_class_e                cls_a,
  input  fp_class_e                cls_b,
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  eu,
  input  logic [2*MAN_W+1:0]       prod,
  output logic [W-1:0]             res,
  output fp_flags_t                flags
);

  localparam int EW = EXP_W + 3;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [MAX_W-1:0] QNAN_FULL = qnan_word(EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN_W = QNAN_FULL[W-1:0];

  logic signed [EW-1:0] e_n;
  logic signed [EW-1:0] e_r;
  logic [MAN_W:0]       m_n;
  logic [MAN_W:0]       m_r;
  logic [MAN_W+1:0]     sum;
  logic                 guard;
  logic                 sticky;
  logic                 up;
  logic                 nan_a, nan_b;
  logic                 snan_any;
  logic                 zero_a, zero_b;
  logic                 inf_a, inf_b;

  always_comb begin
    e_n    = EW'(eu);
    m_n    = prod[2*MAN_W:MAN_W];
    guard  = prod[MAN_W-1];
    sticky = |prod[MAN_W-2:0];
    if (prod[2*MAN_W+1]) begin
      m_n    = prod[2*MAN_W+1:MAN_W+1];
      guard  = prod[MAN_W];
      sticky = |prod[MAN_W-1:0];
      e_n    = EW'(eu) + EW'(1);
    end
    up  = guard & (sticky | m_n[0]);
    sum = {1'b0, m_n} + (MAN_W+2)'(up);
    m_r = sum[MAN_W:0];
    e_r = e_n;
    // Carry out of rounding leaves 1.000..0 one binade up.
    if (sum[MAN_W+1]) begin
      m_r = sum[MAN_W+1:1];
      e_r = e_n + EW'(1);
    end
  end

  assign nan_a    = (cls_a == QNAN) || (cls_a == SNAN);
  assign nan_b    = (cls_b == QNAN) || (cls_b == SNAN);
  assign snan_any = (cls_a == SNAN) || (cls_b == SNAN);
  assign zero_a   = (cls_a == ZERO);
  assign zero_b   = (cls_b == ZERO);
  assign inf_a    = (cls_a == INF);
  assign inf_b    = (cls_b == INF);

  always_comb begin
    res   = '0;
    flags = '0;
    if (nan_a || nan_b) begin
      res           = QNAN_W;
      flags.invalid = snan_any;
    end else if ((zero_a && inf_b) || (inf_a && zero_b)) begin
      res           = QNAN_W;
      flags.invalid = 1'b1;
    end else if (inf_a || inf_b) begin
      res = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      res = {sign, {(W-1){1'b0}}};
    end else if (e_r >= EW'(EMAX)) begin
      res            = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags.overflow = 1'b1;
      flags.inexact  = 1'b1;
    end else if (e_r <= EW'(0)) begin
      res             = {sign, {(W-1){1'b0}}};
      flags.underflow = 1'b1;
      flags.inexact   = 1'b1;
    end else begin
      res           = {sign, e_r[EXP_W-1:0], m_r[MAN_W-1:0]};
      flags.inexact = guard | sticky;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined FP multiplier with valid/ready handshake.
// Whole pipe freezes on output backpressure; bubbles are kept.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = calc_w(EXP_W, MAN_W)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid,
  output logic         inexact
);

  localparam int BIAS = calc_bias(EXP_W);
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2*MAN_W + 2;

  logic               stall;
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   fa, fb;
  fp_class_e          cls_a_in, cls_b_in;
  logic [EW-1:0]      eu_in;

  logic               v1, v2;
  fp_class_e          cls_a1, cls_b1, cls_a2, cls_b2;
  logic               sign1, sign2;
  logic signed [EW-1:0] eu1, eu2;
  logic [MAN_W:0]     ma1, mb1;
  logic [PW-1:0]      prod2;

  logic [W-1:0]       rn_res;
  fp_flags_t          rn_flags;
  fp_flags_t          flags_q;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign {sa, ea, fa} = a_in;
  assign {sb, eb, fb} = b_in;

  assign cls_a_in = classify(&ea, ~|ea, ~|fa, fa[MAN_W-1]);
  assign cls_b_in = classify(&eb, ~|eb, ~|fb, fb[MAN_W-1]);
  assign eu_in    = {2'b00, ea} + {2'b00, eb} - EW'(BIAS);

  always_ff @(posedge clock) begin
    if (!reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      product   <= '0;
      flags_q   <= '0;
    end else if (!stall) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      product   <= v2 ? rn_res : '0;
      flags_q   <= v2 ? rn_flags : '0;
    end
  end

  // Payload registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clock) begin
    if (!stall) begin
      cls_a1 <= cls_a_in;
      cls_b1 <= cls_b_in;
      sign1  <= sa ^ sb;
      eu1    <= eu_in;
      ma1    <= {1'b1, fa};
      mb1    <= {1'b1, fb};
      cls_a2 <= cls_a1;
      cls_b2 <= cls_b1;
      sign2  <= sign1;
      eu2    <= eu1;
      prod2  <= PW'(ma1) * PW'(mb1);
    end
  end

  fp_round_norm #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_norm (
    .cls_a (cls_a2),
    .cls_b (cls_b2),
    .sign  (sign2),
    .eu    (eu2),
    .prod  (prod2),
    .res   (rn_res),
    .flags (rn_flags)
  );

  assign overflow  = flags_q.overflow;
  assign underflow = flags_q.underflow;
  assign invalid   = flags_q.invalid;
  assign inexact   = flags_q.inexact;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (binary32 configuration).
// Directed vectors, random traffic, backpressure and mid-flight reset.
module tb_fp_mult_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] product;
  logic        overflow, underflow, invalid, inexact;
  logic [3:0]  flags;

  always #5 clock = ~clock;

  fp_mult_pipe #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  assign flags = {overflow, underflow, invalid, inexact};

  typedef struct {
    logic [31:0] p;
    logic [3:0]  f;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          acc_cnt = 0;
  logic [31:0] cur_p = '0;
  logic [3:0]  cur_f = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_prod = '0;
  logic [3:0]  prev_flags = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cls(input logic [31:0] x);
    if (x[30:23] == 8'h00) return 0;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] == 23'h0) return 2;
      return x[22] ? 3 : 4;
    end
    return 1;
  endfunction

  // Reference: exact integer product, then remainder-vs-half rounding.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] p, output logic [3:0] f);
    int ca, cb, e, sh;
    logic s;
    longint unsigned pr, q, r, half;
    ca = cls(a);
    cb = cls(b);
    s  = a[31] ^ b[31];
    p  = '0;
    f  = '0;
    if (ca >= 3 || cb >= 3) begin
      p    = 32'h7FC00000;
      f[1] = (ca == 4 || cb == 4);
    end else if ((ca == 0 && cb == 2) || (ca == 2 && cb == 0)) begin
      p = 32'h7FC00000;
      f = 4'b0010;
    end else if (ca == 2 || cb == 2) begin
      p = {s, 8'hFF, 23'h0};
    end else if (ca == 0 || cb == 0) begin
      p = {s, 31'h0};
    end else begin
      pr = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
      e  = int'(a[30:23]) + int'(b[30:23]) - 127;
      sh = 23;
      if ((pr >> 47) != 0) begin
        sh = 24;
        e++;
      end
      q    = pr >> sh;
      r    = pr - (q << sh);
      half = 64'd1 << (sh - 1);
      if (r > half || (r == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
      if (e >= 255) begin
        p = {s, 8'hFF, 23'h0};
        f = 4'b1001;
      end else if (e <= 0) begin
        p = {s, 31'h0};
        f = 4'b0101;
      end else begin
        p = {s, 8'(e), q[22:0]};
        f = {3'b000, r != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    x = $urandom;
    if ($urandom_range(0, 3) != 0) x[30:23] = 8'($urandom_range(90, 165));
    return x;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_prod", product, prev_prod);
        chk("stall_hold_flags", flags, prev_flags);
        chk("stall_hold_valid", out_valid, 1'b1);
      end
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("product", product, e.p);
          chk("flags", flags, e.f);
        end
      end
      if (in_valid && in_ready) begin
        e.p = cur_p;
        e.f = cur_f;
        sb.push_back(e);
        acc_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_prod  = product;
      prev_flags = flags;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ep, input logic [3:0] ef);
    bit ok;
    ok       = 1'b0;
    a_in     = a;
    b_in     = b;
    cur_p    = ep;
    cur_f    = ef;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      if (!ok) out_ready = 1'b1;
    end
    chk("accept_timeout", ok, 1'b1);
  endtask

  task automatic send_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    logic [3:0]  f;
    model(a, b, p, f);
    send(a, b, p, f);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clock);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  localparam int ND = 13;
  logic [31:0] da [ND] = '{32'h3FC00000, 32'h3F800001, 32'h3F800003,
                           32'h7F000000, 32'h00800000, 32'h80800000,
                           32'h00000000, 32'h7F800001, 32'hFF800000,
                           32'h00000001, 32'h7FC00000, 32'h3F800001,
                           32'h3F800003};
  logic [31:0] db [ND] = '{32'h40000000, 32'h3F800001, 32'h3F800000,
                           32'h7F000000, 32'h3F000000, 32'h3F000000,
                           32'h7F800000, 32'h3F800000, 32'h40000000,
                           32'h40000000, 32'h3F800000, 32'h3FC00000,
                           32'h3FC00000};
  logic [31:0] dp [ND] = '{32'h40400000, 32'h3F800002, 32'h3F800003,
                           32'h7F800000, 32'h00000000, 32'h80000000,
                           32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                           32'h00000000, 32'h7FC00000, 32'h3FC00002,
                           32'h3FC00004};
  logic [3:0]  df [ND] = '{4'b0000, 4'b0001, 4'b0000,
                           4'b1001, 4'b0101, 4'b0101,
                           4'b0010, 4'b0010, 4'b0000,
                           4'b0000, 4'b0000, 4'b0001,
                           4'b0001};

  initial begin
    bit ok;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_product", product, 32'h0);
    chk("rst_flags", flags, 4'h0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    send(da[0], db[0], dp[0], df[0]);
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("latency_2", out_valid, 1'b0);
    @(posedge clock);
    #1;
    chk("latency_3", out_valid, 1'b1);
    drain();

    for (int i = 1; i < ND; i++) send(da[i], db[i], dp[i], df[i]);
    drain();

    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send_model(rnd_op(), rnd_op());
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clock);
        #1;
      end
    end
    drain();

    acc_cnt   = 0;
    out_ready = 1'b0;
    ra = rnd_op();
    rb = rnd_op();
    model(ra, rb, cur_p, cur_f);
    a_in     = ra;
    b_in     = rb;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      if (ok) begin
        ra   = rnd_op();
        rb   = rnd_op();
        a_in = ra;
        b_in = rb;
        model(ra, rb, cur_p, cur_f);
      end
    end
    chk("bp_accepted", acc_cnt, 3);
    chk("bp_in_ready", in_ready, 1'b0);
    drain();

    send_model(32'h3FC00000, 32'h40400000);
    send_model(32'h40000000, 32'h40000000);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_flags", flags, 4'h0);
    chk("mid_rst_product", product, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      chk("no_stale", out_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point multiplier.
- Next generation of the FPALU single-cycle multiplier.
- Adds configurable exponent/mantissa widths, a 3-stage pipeline with valid/ready handshake, round-to-nearest-even, and a full exception flag set.
- Sits in the FPALU datapath beside the adder. Accepts one operation per cycle when not stalled.

Parameters:
- EXP_W, 8: exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width; total word width W = 1+EXP_W+MAN_W.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-low reset. Sampled only on the rising edge of clock.
- in_valid, input, 1: a_in/b_in hold a valid operation.
- in_ready, output, 1: the pipe accepts the operation this cycle.
- a_in, input, W: operand A (sign|exponent|fraction).
- b_in, input, W: operand B.
- out_valid, output, 1: product/flags valid.
- out_ready, input, 1: consumer accepts the result this cycle.
- product, output, W: result word.
- overflow, output, 1: result exceeded the max finite value, forced to infinity.
- underflow, output, 1: nonzero result below min normal, flushed to zero.
- invalid, output, 1: 0*inf, or any signalling-NaN input.
- inexact, output, 1: rounding discarded nonzero bits, or overflow/underflow occurred.

Behaviour:
- Reset (reset==0 at a clock edge): all stage valids, out_valid, product and every flag go to 0 on that edge. In-flight operations are discarded. in_ready=1 from the first cycle after reset is released.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
  - During a stall, every stage register holds and the outputs stay stable.
  - Bubbles are not compressed.
- Latency: exactly 3 clocks from input transfer to out_valid when unstalled. Throughput: 1 per clock.
- S1 (register): classify each operand as ZERO, NORM, INF, QNAN or SNAN.
  - Subnormal inputs (exponent 0, fraction nonzero) count as ZERO (flush-to-zero).
  - Compute sign = sa^sb.
  - Compute eu = ea+eb-BIAS as a signed value, EXP_W+2 bits.
  - Register the mantissas with the hidden 1.
- S2 (register): (MAN_W+1)x(MAN_W+1) unsigned product, 2*MAN_W+2 bits.
- S3 (register), normalise:
  - If the product MSB is 1, shift right by 1 and eu+1.
  - Guard = next bit below the kept MAN_W+1 bits; sticky = OR of all lower bits.
  - Round to nearest, ties to even.
  - If rounding carries out, shift right by 1 and eu+1.
- Special-case priority (highest first):
  1. Any NaN input -> canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0). invalid=1 only if either input is SNAN.
  2. ZERO*INF -> canonical qNaN, invalid=1.
  3. INF*any -> signed infinity, no flags.
  4. ZERO*any -> signed zero, no flags.
  5. Otherwise the normal path.
- Normal path boundaries:
  - Final eu >= 2^EXP_W-1 -> signed infinity, overflow=1, inexact=1.
  - Final eu <= 0 -> signed zero, underflow=1, inexact=1.
  - Otherwise pack normally; inexact = guard|sticky.
- Flags are sticky only per result; they are registered with product and valid only while out_valid=1.

Decomposition:
- Package fp_mult_pkg:
  - Class enum {ZERO, NORM, INF, QNAN, SNAN}.
  - Functions deriving W and BIAS from EXP_W/MAN_W.
  - Canonical-qNaN constant builder.
  - Flag struct {overflow, underflow, invalid, inexact}.
- Sub-module fp_round_norm: S3 combinational normalise, round, pack and exception logic. Instantiated once in S3.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0), out_ready=1 -> after 3 clocks 0x40400000, all flags 0.
- 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact=1 (RNE rounds down the sticky-only remainder). Then 0x3F800003 * 0x3F800000 -> 0x3F800003, inexact=0.
- 0x7F000000 * 0x7F000000 -> 0x7F800000, overflow=1, inexact=1. Then 0x00800000 * 0x3F000000 -> 0x00000000, underflow=1, inexact=1. Then 0x80800000 * 0x3F000000 -> 0x80000000.
- Special cases:
  - 0x00000000 * 0x7F800000 -> 0x7FC00000, invalid=1.
  - 0x7F800001 * 0x3F800000 -> 0x7FC00000, invalid=1.
  - 0xFF800000 * 0x40000000 -> 0xFF800000, no flags.
  - 0x00000001 (subnormal) * 0x40000000 -> 0x00000000, no flags.
- Backpressure: hold out_ready=0 with in_valid=1 continuously -> exactly 3 operations accepted, in_ready=0 from the cycle out_valid rises. Raise out_ready -> results drain in order with no loss or duplication.
- Drive reset=0 for one clock with 2 operations in flight -> out_valid=0 and flags 0 after that edge. No stale result emerges afterwards.
